// File: rtl/fill_pkg.sv
// Shared types for the memory fill engine: fill patterns and controller states.
package fill_pkg;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        CONST    = 2'd1,
        REVERSE  = 2'd2,
        STRIDE   = 2'd3
    } fill_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/mem_fill_engine_if.sv
// Control and memory-write bundle between a fill requester and the fill engine.
interface mem_fill_engine_if
    import fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    fill_mode_t        mode;
    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] step;
    logic              stall;
    logic              abort;
    logic              wr_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              bus_owner;

    modport master (
        output start, mode, seed, step, stall, abort,
        input  wr_en, address, data, busy, done, bus_owner
    );

    modport slave (
        input  start, mode, seed, step, stall, abort,
        output wr_en, address, data, busy, done, bus_owner
    );
endinterface

// File: rtl/fill_data_gen.sv
// Write-data generator: holds the stride accumulator and selects the pattern word.
module fill_data_gen
    import fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic              i_advance,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_seed,
    input  logic [DATA_W-1:0] i_step,
    input  fill_mode_t        i_mode,
    output logic [DATA_W-1:0] o_data
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_acc;
    logic [ADDR_W-1:0] w_rev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_seed;
        end else if (i_advance) begin
            r_acc <= r_acc + i_step;
        end
    end

    // idx never exceeds LAST_IDX, so this subtraction cannot underflow
    assign w_rev = LAST_IDX - i_idx;

    always_comb begin
        o_data = '0;
        case (i_mode)
            IDENTITY: o_data = DATA_W'(i_idx);
            CONST:    o_data = i_seed;
            REVERSE:  o_data = DATA_W'(w_rev);
            STRIDE:   o_data = r_acc;
        endcase
    end
endmodule

// File: rtl/mem_fill_engine.sv
// RAM fill controller: writes DEPTH words from address 0 using a latched pattern.
// state | meaning
// IDLE  | waiting for start; memory mux not owned
// FILL  | one write per unstalled cycle, address = idx
// DONE  | one-cycle done pulse, then back to IDLE
module mem_fill_engine
    import fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input logic             clk,
    input logic             rst,
    mem_fill_engine_if.slave fill_bus
);
    generate
        if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_depth_chk
            $error("mem_fill_engine: DEPTH must lie in 1..2**ADDR_W");
        end
    endgenerate

    // terminal compare keeps idx at ADDR_W bits even for a full-depth fill
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    fill_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    fill_mode_t        r_mode;
    logic [DATA_W-1:0] r_seed, r_step;
    logic [DATA_W-1:0] w_gen_seed, w_gen_data;
    logic              w_start_acc, w_in_fill, w_adv, w_last;

    assign w_start_acc = (r_state == IDLE) && fill_bus.start;
    assign w_in_fill   = (r_state == FILL);
    assign w_adv       = w_in_fill && !fill_bus.abort && !fill_bus.stall;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_gen_seed  = w_start_acc ? fill_bus.seed : r_seed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_mode <= IDENTITY;
            r_seed <= '0;
            r_step <= '0;
        end else if (w_start_acc) begin
            r_idx  <= '0;
            r_mode <= fill_bus.mode;
            r_seed <= fill_bus.seed;
            r_step <= fill_bus.step;
        end else if (w_adv && !w_last) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        fill_bus.wr_en     = 1'b0;
        fill_bus.busy      = 1'b0;
        fill_bus.done      = 1'b0;
        fill_bus.bus_owner = 1'b0;
        fill_bus.address   = '0;
        fill_bus.data      = '0;
        case (r_state)
            IDLE: begin
                if (fill_bus.start) w_state_nxt = FILL;
            end
            FILL: begin
                fill_bus.wr_en     = w_adv;
                fill_bus.busy      = 1'b1;
                fill_bus.bus_owner = 1'b1;
                fill_bus.address   = r_idx;
                fill_bus.data      = w_gen_data;
                if (fill_bus.abort) begin
                    w_state_nxt = IDLE;
                end else if (!fill_bus.stall && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                fill_bus.busy = 1'b1;
                fill_bus.done = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    fill_data_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_data_gen (
        .clk       (clk),
        .rst       (rst),
        .i_idx     (r_idx),
        .i_advance (w_adv && !w_last),
        .i_load    (w_start_acc),
        .i_seed    (w_gen_seed),
        .i_step    (r_step),
        .i_mode    (r_mode),
        .o_data    (w_gen_data)
    );
endmodule

// File: tb/tb_mem_fill_engine.sv
// Scoreboard bench: three engines of different depth driven with random fills.
module tb_mem_fill_engine;
    import fill_pkg::*;

    localparam int NI = 3;
    localparam int DEPTHS [NI] = '{256, 10, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [NI-1:0]       start_v, stall_v, abort_v;
    logic [NI-1:0][1:0]  mode_v;
    logic [NI-1:0][7:0]  seed_v, step_v;
    logic [NI-1:0]       wr_en_v, busy_v, done_v, own_v;
    logic [NI-1:0][7:0]  addr_v, data_v;

    mem_fill_engine_if #(.ADDR_W(8), .DATA_W(8)) ifs [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTHS[g])) dut (
            .clk      (clk),
            .rst      (rst),
            .fill_bus (ifs[g].slave)
        );
        assign ifs[g].start = start_v[g];
        assign ifs[g].mode  = fill_mode_t'(mode_v[g]);
        assign ifs[g].seed  = seed_v[g];
        assign ifs[g].step  = step_v[g];
        assign ifs[g].stall = stall_v[g];
        assign ifs[g].abort = abort_v[g];
        assign wr_en_v[g]   = ifs[g].wr_en;
        assign busy_v[g]    = ifs[g].busy;
        assign done_v[g]    = ifs[g].done;
        assign own_v[g]     = ifs[g].bus_owner;
        assign addr_v[g]    = ifs[g].address;
        assign data_v[g]    = ifs[g].data;
    end

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q [NI][$];
    int wr_cnt [NI];
    int done_cnt [NI];
    bit exp_done [NI];
    int t_start [NI];
    int exp_lat [NI];

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h), cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Pattern word for position i of a DEPTH-d fill, straight from the pattern definitions.
    function automatic logic [7:0] model_data(int mode, int d, int i, int seed, int step);
        case (mode)
            0:       return 8'(i);
            1:       return 8'(seed);
            2:       return 8'(d - 1 - i);
            default: return 8'(seed + i * step);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                if (wr_en_v[k]) begin
                    logic [15:0] e;
                    wr_cnt[k]++;
                    chk("owner_during_write", int'(own_v[k]), 1);
                    chk("write_has_expectation", int'(exp_q[k].size() > 0), 1);
                    if (exp_q[k].size() > 0) begin
                        e = exp_q[k].pop_front();
                        chk("write_addr", int'(addr_v[k]), int'(e[15:8]));
                        chk("write_data", int'(data_v[k]), int'(e[7:0]));
                    end
                end else if (!own_v[k]) begin
                    chk("addr_zero_outside_fill", int'(addr_v[k]), 0);
                    chk("data_zero_outside_fill", int'(data_v[k]), 0);
                end
                if (done_v[k]) begin
                    done_cnt[k]++;
                    chk("done_expected", int'(exp_done[k]), 1);
                    chk("done_after_last_write", exp_q[k].size(), 0);
                    chk("done_busy_high", int'(busy_v[k]), 1);
                    chk("done_owner_low", int'(own_v[k]), 0);
                    if (exp_lat[k] > 0) chk("done_latency", cyc - t_start[k], exp_lat[k]);
                    exp_done[k] = 1'b0;
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        for (int j = 0; j < NI; j++) begin
            chk(name, int'({wr_en_v[j], busy_v[j], done_v[j], own_v[j], addr_v[j], data_v[j]}), 0);
        end
    endtask

    task automatic run_fill(input int k, input int mode, input int seed, input int step,
                            input int stall_pct, input int abort_at, input int rst_at,
                            input bit hold_start);
        int  d;
        int  n;
        int  w;
        int  wr_base;
        int  done_base;
        bit  finished;
        bit  want_done;
        d         = DEPTHS[k];
        finished  = 1'b0;
        n         = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : d;
        want_done = (abort_at < 0) && (rst_at < 0);
        for (int i = 0; i < n; i++) exp_q[k].push_back({8'(i), model_data(mode, d, i, seed, step)});
        exp_done[k] = want_done;
        exp_lat[k]  = (stall_pct == 0 && want_done) ? d + 1 : 0;
        wr_base     = wr_cnt[k];
        done_base   = done_cnt[k];

        @(posedge clk); #1;
        start_v[k] = 1'b1;
        mode_v[k]  = 2'(mode);
        seed_v[k]  = 8'(seed);
        step_v[k]  = 8'(step);
        stall_v[k] = 1'($urandom_range(1));
        t_start[k] = cyc;
        @(posedge clk); #1;
        if (!hold_start) start_v[k] = 1'b0;
        mode_v[k] = 2'($urandom);
        seed_v[k] = 8'($urandom);
        step_v[k] = 8'($urandom);

        for (int c = 0; c < 4 * d + 40 && !finished; c++) begin
            w = wr_cnt[k] - wr_base;
            if (abort_at >= 0 && w == abort_at) begin
                abort_v[k] = 1'b1;
                stall_v[k] = 1'($urandom_range(1));
                @(posedge clk); #1;
                abort_v[k] = 1'b0;
                chk("busy_after_abort", int'(busy_v[k]), 0);
                finished = 1'b1;
            end else if (rst_at >= 0 && w == rst_at) begin
                rst = 1'b1;
                #1;
                for (int r = 0; r < 3; r++) begin
                    chk_all_zero("outputs_in_reset");
                    @(posedge clk); #1;
                end
                rst = 1'b0;
                finished = 1'b1;
            end else if (done_v[k]) begin
                @(posedge clk); #1;
                start_v[k] = 1'b0;
                finished = 1'b1;
            end else begin
                stall_v[k] = ($urandom_range(99) < stall_pct);
                @(posedge clk); #1;
            end
        end
        chk("fill_finished_in_budget", int'(finished), 1);
        start_v[k] = 1'b0;
        stall_v[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("write_count", wr_cnt[k] - wr_base, n);
        chk("done_count", done_cnt[k] - done_base, int'(want_done));
        chk("queue_drained", exp_q[k].size(), 0);
        chk("busy_low_after", int'(busy_v[k]), 0);
        chk("owner_low_after", int'(own_v[k]), 0);
        exp_q[k].delete();
        exp_done[k] = 1'b0;
        exp_lat[k]  = 0;
    endtask

    initial begin
        int k;
        int d;
        start_v = '0;
        stall_v = '0;
        abort_v = '0;
        mode_v  = '0;
        seed_v  = '0;
        step_v  = '0;
        for (int j = 0; j < NI; j++) begin
            wr_cnt[j]   = 0;
            done_cnt[j] = 0;
            exp_done[j] = 1'b0;
            t_start[j]  = 0;
            exp_lat[j]  = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        rst = 1'b0;

        run_fill(0, 0, 0, 0, 0, -1, -1, 1'b0);
        run_fill(0, 2, int'($urandom_range(255)), 0, 0, -1, -1, 1'b0);
        run_fill(1, 3, 'hF0, 'h07, 0, -1, -1, 1'b0);
        run_fill(2, 1, 'hA5, 0, 50, -1, -1, 1'b0);
        run_fill(0, 0, 0, 0, 0, 5, -1, 1'b0);
        run_fill(0, 0, 0, 0, 0, -1, -1, 1'b0);
        run_fill(2, 3, int'($urandom_range(255)), int'($urandom_range(255)), 0, 5, -1, 1'b0);
        run_fill(0, 3, int'($urandom_range(255)), int'($urandom_range(255)), 0, -1, 100, 1'b0);
        run_fill(0, 1, 'h5A, 0, 0, -1, -1, 1'b1);

        repeat (12) begin
            k = int'($urandom_range(NI - 1));
            d = DEPTHS[k];
            run_fill(k, int'($urandom_range(3)), int'($urandom_range(255)),
                     int'($urandom_range(255)), int'($urandom_range(40)),
                     ($urandom_range(3) == 0) ? int'($urandom_range(d - 1)) : -1,
                     -1, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
